// File: rtl/mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_unit
// Purpose  : RV32I memory-access stage: data-memory handshake, byte/halfword
//            formatting, MEM/WB register, stall generation and access watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [72:0] exmem_bus,
   input  logic [2:0]  mem_funct3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [31:0] fault_addr
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic        reg_write;
   logic [31:0] alu_result;
   logic [31:0] r2_data;
   logic [4:0]  rd;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;

   assign {reg_write, alu_result, r2_data, rd, mem_read, mem_write, mem_to_reg} = exmem_bus;

   logic mem_op;
   logic f3_ok;
   logic is_half;
   logic is_word;
   logic misaligned;
   logic access_ok;
   logic fault_op;

   assign mem_op = mem_read | mem_write;

   // A read-and-write op never matches either branch and stays illegal.
   always_comb begin
      f3_ok = 1'b0;
      if (mem_read && !mem_write) begin
         case (mem_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else if (mem_write && !mem_read) begin
         case (mem_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
   end

   assign is_half    = (mem_funct3[1:0] == 2'b01);
   assign is_word    = (mem_funct3[1:0] == 2'b10);
   assign misaligned = (is_half & alu_result[0]) | (is_word & (alu_result[1:0] != 2'b00));
   assign access_ok  = mem_op & f3_ok & ~misaligned;
   assign fault_op   = mem_op & ~access_ok;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   assign dmem_req  = reset & access_ok & (state_q != ST_ABORT);
   assign stall     = dmem_req & ~dmem_ready;
   assign dmem_we   = mem_write & ~mem_read;
   assign dmem_addr = {alu_result[31:2], 2'b00};

   always_comb begin
      dmem_wdata = 32'h0;
      dmem_be    = 4'b1111;
      if (mem_write && !mem_read) begin
         case (mem_funct3[1:0])
            2'b00: begin
               dmem_wdata = {4{r2_data[7:0]}};
               dmem_be    = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
               dmem_wdata = {2{r2_data[15:0]}};
               dmem_be    = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               dmem_wdata = r2_data;
               dmem_be    = 4'b1111;
            end
         endcase
      end
   end

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   always_comb begin
      case (alu_result[1:0])
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (mem_funct3)
         3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_value = {24'h0, ld_byte};
         3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_value = {16'h0, ld_half};
         default: ld_value = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      fault_d        = 1'b0;
      fault_addr_d   = fault_addr_q;

      if (state_q == ST_ABORT) begin
         // The held op is retired here as a bubble; upstream advances now.
         wb_reg_write_d = 1'b0;
         fault_d        = 1'b1;
         fault_addr_d   = alu_result;
         state_d        = ST_IDLE;
         cnt_d          = 8'd0;
      end else if (fault_op) begin
         wb_reg_write_d = 1'b0;
         fault_d        = 1'b1;
         fault_addr_d   = alu_result;
         state_d        = ST_IDLE;
         cnt_d          = 8'd0;
      end else if (stall) begin
         wb_reg_write_d = 1'b0;
         if (state_q == ST_IDLE) begin
            state_d = ST_BUSY;
            cnt_d   = 8'd1;
         end else if (cnt_q == CNT_LIMIT) begin
            state_d = ST_ABORT;
            cnt_d   = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         // Completed access or non-memory op: ready=1 always beats the watchdog.
         wb_reg_write_d = reg_write & (rd != 5'd0);
         wb_rd_d        = rd;
         wb_data_d      = mem_to_reg ? ld_value : alu_result;
         state_d        = ST_IDLE;
         cnt_d          = 8'd0;
      end
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 8'd0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= 32'h0;
         fault_q        <= 1'b0;
         fault_addr_q   <= 32'h0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         fault_q        <= fault_d;
         fault_addr_q   <= fault_addr_d;
      end
   end

   assign wb_reg_write = wb_reg_write_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign fault        = fault_q;
   assign fault_addr   = fault_addr_q;

endmodule
`default_nettype wire
